psum_collector: RTL

Output-side companion to the systolic PE grid. It sits below the bottom row of the N-column weight-stationary array and accepts the skewed partial sums that leave each column one cycle apart. It de-skews them into complete result rows and buffers those rows in a small FIFO. It presents the rows to downstream logic over a valid/ready handshake. The array cannot be stalled, so rows that find the FIFO full are dropped and flagged.

---
 rtl/psum_collector.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/psum_collector.sv
`default_nettype none
// ============================================================================
// Module   : psum_collector
// Purpose  : De-skews the staggered partial sums leaving the bottom row of an
//            N-column systolic array into whole result rows and buffers them
//            in a DEPTH-entry FIFO with a valid/ready output. Rows that find
//            the FIFO full are dropped and counted, since the array cannot
//            be stalled.
// Options  : PSUM_COLLECTOR_RELU_EN - clamp negative column values to zero
//            before the FIFO write.
// Revision : 1.0 - initial release
// ============================================================================
module psum_collector #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [N*DW-1:0] psum_in,
  input  logic            in_valid,
  output logic [N*DW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  output logic [7:0]      drop_count,
  output logic [15:0]     rows_out
);

  localparam int c_AW = $clog2(DEPTH);

  // Reset and clear act identically on every piece of state.
  logic w_flush;
  assign w_flush = !rst_n || clear;

  // Row as it lines up at cycle c+N-1, before and after optional clamping.
  logic [N*DW-1:0] w_aligned;
  logic [N*DW-1:0] w_row;

  // Column j needs N-1-j stages so that every column meets the last one.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int c_STG = N - 1 - j;
    if (c_STG == 0) begin : g_pass
      assign w_aligned[j*DW +: DW] = psum_in[j*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] dly_q [c_STG];
      // Pure shift register for this column's skew compensation.
      always_ff @(posedge clk) begin
        if (w_flush) begin
          for (int s = 0; s < c_STG; s++) dly_q[s] <= '0;
        end else begin
          dly_q[0] <= psum_in[j*DW +: DW];
          for (int s = 1; s < c_STG; s++) dly_q[s] <= dly_q[s-1];
        end
      end
      assign w_aligned[j*DW +: DW] = dly_q[c_STG-1];
    end
  end

  // Optional per-column clamp; a pass-through in the default build.
  for (genvar j = 0; j < N; j++) begin : g_relu
`ifdef PSUM_COLLECTOR_RELU_EN
    assign w_row[j*DW +: DW] = w_aligned[j*DW+DW-1] ? {DW{1'b0}} : w_aligned[j*DW +: DW];
`else
    assign w_row[j*DW +: DW] = w_aligned[j*DW +: DW];
`endif
  end

  // Valid travels alongside column 0, so it needs the full N-1 stages.
  logic [N-2:0] vld_q;

  // Valid shift register; a flush kills any partially aligned row.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      vld_q <= '0;
    end else begin
      for (int s = N - 2; s > 0; s--) vld_q[s] <= vld_q[s-1];
      vld_q[0] <= in_valid;
    end
  end

  // FIFO state: pointers carry one extra bit to tell full from empty.
  logic [N*DW-1:0] mem_q [DEPTH];
  logic [c_AW:0]   wptr_q, wptr_d;
  logic [c_AW:0]   rptr_q, rptr_d;
  logic            out_valid_q;
  logic            overflow_q;
  logic [7:0]      drop_count_q;
  logic [15:0]     rows_out_q;

  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_drop;

  assign w_full     = (wptr_q[c_AW] != rptr_q[c_AW]) &&
                      (wptr_q[c_AW-1:0] == rptr_q[c_AW-1:0]);
  assign w_pop      = out_valid_q && out_ready;
  assign w_push_req = vld_q[N-2];
  // A same-cycle pop frees the slot, so a full FIFO still accepts the row.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;

  // Next pointer values; also used to register out_valid one cycle early.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_push) wptr_d = wptr_q + {{c_AW{1'b0}}, 1'b1};
    if (w_pop)  rptr_d = rptr_q + {{c_AW{1'b0}}, 1'b1};
  end

  // FIFO storage, pointers, registered valid and status counters.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      rows_out_q   <= '0;
    end else begin
      if (w_push) mem_q[wptr_q[c_AW-1:0]] <= w_row;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= (wptr_d != rptr_d);
      if (w_drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
      if (w_pop) rows_out_q <= rows_out_q + 16'd1;
    end
  end

  assign out_data   = mem_q[rptr_q[c_AW-1:0]];
  assign out_valid  = out_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign rows_out   = rows_out_q;

endmodule
`default_nettype wire
